pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised successor to the fixed-field pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  It is a single elastic pipeline stage with a valid/ready handshake, an optional skid entry
//  for full throughput, synchronous flush (bubble insertion) and a saturating stall counter.
//  One instance sits between each pair of core stages; the field bundle is packed into one payload.
// PARAMETERS
//  DATA_W      32  payload width in bits (>=1)
//  PRESET_VAL  0   value loaded into payload registers on reset and on flush
//  SKID        1   1: 2-entry skid, registered in_ready; 0: 1-entry, in_ready = ~out_valid | out_ready
//  CNT_W       16  stall counter width (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  arst       in   1       asynchronous reset, active high
//  flush      in   1       synchronous flush: discard all held entries
//  in_valid   in   1       upstream has a payload
//  in_ready   out  1       stage accepts payload this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       stage presents a payload
//  out_ready  in   1       downstream accepts this cycle
//  out_data   out  DATA_W  presented payload
//  clr_cnt    in   1       synchronous clear of stall_cnt
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  in_fire  = in_valid & in_ready & ~flush.
//  out_fire = out_valid & out_ready.
//  Reset (arst=1, asynchronous): state EMPTY; out_valid=0; out_data=PRESET_VAL; skid=PRESET_VAL;
//   stall_cnt=0; in_ready=0 while arst is high.
//  States: EMPTY (no entry), ONE (main valid), FULL (main+skid valid; reachable only with SKID=1).
//  out_valid=1 in ONE and FULL; out_data is always the main register (registered, no comb path).
//  SKID=1: in_ready = ~FULL, driven from a register; no comb path from out_ready.
//   EMPTY: in_fire -> ONE, main<=in_data.
//   ONE:   in_fire&out_fire -> ONE, main<=in_data; in_fire&~out_fire -> FULL, skid<=in_data;
//          ~in_fire&out_fire -> EMPTY; otherwise hold.
//   FULL:  out_fire -> ONE, main<=skid; otherwise hold. No in_fire is possible in FULL.
//  SKID=0: in_ready = ~out_valid | out_ready (combinational). in_fire -> ONE, main<=in_data;
//   ~in_fire & out_fire -> EMPTY.
//  Latency: 1 cycle from in_fire to out_valid. Throughput is 1/cycle in both modes while out_ready=1.
//  Order is strict FIFO; no payload is duplicated or dropped except on flush.
//  Flush (priority below arst, above all else): in_ready is forced 0 in that cycle; next state EMPTY;
//   main and skid are loaded with PRESET_VAL. An out_fire in the flush cycle counts as delivered.
//  Payload registers load only on capture/flush/reset; they hold their value when idle.
//  stall_cnt: +1 per cycle with out_valid & ~out_ready; saturates at 2^CNT_W-1 (no wrap).
//   clr_cnt wins over increment (result 0). Flush does not affect the counter.
// TESTING
//  1 Reset mid-traffic: assert arst with FULL -> out_valid=0, out_data=0, in_ready=0 async; stall_cnt=0.
//  2 Streaming, SKID=1, out_ready=1: 0x11,0x22,0x33 on consecutive cycles -> same order on out, 1-cycle lag.
//  3 Back-pressure: out_ready=0, send 0xA1,0xA2 -> FULL, in_ready=0; release -> 0xA1 then 0xA2, no loss.
//  4 Flush while FULL with in_valid=1 (0xB3) -> next cycle out_valid=0, out_data=PRESET_VAL, 0xB3 dropped.
//  5 SKID=0: out_valid=1 and out_ready=0 -> in_ready=0; raise out_ready -> in_ready=1 in the same cycle.
//  6 CNT_W=3: hold out_ready=0 for 10 cycles -> stall_cnt=7; clr_cnt with stall ongoing -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   One elastic pipeline stage with a valid/ready handshake. The whole field
//   bundle of a core stage boundary travels as a single packed payload.
//   With SKID=1 a second (skid) entry lets in_ready come from a register, so
//   there is no combinational path from out_ready, and the stage still
//   sustains one transfer per cycle. With SKID=0 the stage holds one entry
//   and in_ready is a combinational function of out_ready.
//   The stage also has a synchronous flush, which turns held entries into a
//   bubble, and a saturating counter of stalled cycles.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   arst       asynchronous reset, active high
//   flush      synchronous flush, discards all held entries
//   in_valid   upstream presents a payload
//   in_ready   stage accepts a payload this cycle
//   in_data    upstream payload
//   out_valid  stage presents a payload
//   out_ready  downstream accepts this cycle
//   out_data   presented payload, always the main register
//   clr_cnt    synchronous clear of stall_cnt
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
//
// State   | meaning
// EMPTY   | no entry held
// ONE     | main register valid
// FULL    | main and skid registers valid (SKID=1 only)

`timescale 1ns/1ps

module pipe_stage_elastic #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  parameter bit                SKID       = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  // rdy_q resets to 1 but arst masks it, so in_ready is low during reset and
  // high in the first cycle after release.
  assign in_ready = ~arst & ~flush & (SKID ? rdy_q : (~out_valid | out_ready));

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = PRESET_VAL;
      skid_d  = PRESET_VAL;
    end else if (SKID) begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      if (in_fire) begin
        state_d = ONE;
        main_d  = in_data;
      end else if (out_fire) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= EMPTY;
      main_q  <= PRESET_VAL;
      skid_q  <= PRESET_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  // Flush leaves the counter alone; the stall is judged on the registered
  // out_valid of the current cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
`timescale 1ns/1ps

module tb_pipe_stage_elastic;

  logic       clk;
  logic       arst;
  logic       flush     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       clr_cnt   [2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int n_chk;
  int n_fail;

  // Reference model: a bounded FIFO per instance plus the last value left
  // on the output when the stage ran empty.
  int unsigned mlen  [2];
  logic [7:0]  mq    [2][2];
  logic [7:0]  mheld [2];
  int unsigned mcnt  [2];

  pipe_stage_elastic #(.DATA_W(8), .PRESET_VAL(8'h00), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .arst(arst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .clr_cnt(clr_cnt[0]), .stall_cnt(cnt0)
  );

  pipe_stage_elastic #(.DATA_W(8), .PRESET_VAL(8'hC3), .SKID(1'b0), .CNT_W(3)) u_nosk (
    .clk(clk), .arst(arst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .clr_cnt(clr_cnt[1]), .stall_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pre(int k);
    return (k == 0) ? 8'h00 : 8'hC3;
  endfunction

  function automatic int unsigned cmax(int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  function automatic logic [31:0] get_cnt(int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  function automatic bit exp_rdy(int k);
    if (flush[k]) return 1'b0;
    if (k == 0) return mlen[0] < 2;
    return (mlen[1] == 0) || out_ready[1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mlen[k]  = 0;
      mheld[k] = pre(k);
      mcnt[k]  = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.u%0d.in_ready", tag, k), 32'(in_ready[k]), 32'd0);
      chk($sformatf("%s.u%0d.out_valid", tag, k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("%s.u%0d.out_data", tag, k), 32'(out_data[k]), 32'(pre(k)));
      chk($sformatf("%s.u%0d.stall_cnt", tag, k), get_cnt(k), 32'd0);
    end
  endtask

  task automatic drv(int k, bit v, logic [7:0] d, bit r, bit f, bit c);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = r;
    flush[k]     = f;
    clr_cnt[k]   = c;
  endtask

  // Called just after a falling edge with inputs applied; checks outputs
  // against the model, advances one rising edge, updates the model and
  // returns at the next falling edge.
  task automatic tick();
    bit inf  [2];
    bit outf [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.in_ready", k), 32'(in_ready[k]), 32'(exp_rdy(k)));
      chk($sformatf("u%0d.out_valid", k), 32'(out_valid[k]), 32'(mlen[k] != 0));
      chk($sformatf("u%0d.out_data", k), 32'(out_data[k]),
          32'((mlen[k] != 0) ? mq[k][0] : mheld[k]));
      chk($sformatf("u%0d.stall_cnt", k), get_cnt(k), 32'(mcnt[k]));
      inf[k]  = in_valid[k] && exp_rdy(k);
      outf[k] = (mlen[k] != 0) && out_ready[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clr_cnt[k]) mcnt[k] = 0;
      else if ((mlen[k] != 0) && !out_ready[k] && (mcnt[k] < cmax(k))) mcnt[k]++;
      if (outf[k]) begin
        mheld[k] = mq[k][0];
        mq[k][0] = mq[k][1];
        mlen[k]--;
      end
      if (flush[k]) begin
        mlen[k]  = 0;
        mheld[k] = pre(k);
      end else if (inf[k]) begin
        mq[k][mlen[k]] = in_data[k];
        mlen[k]++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    arst   = 1'b1;
    drv(0, 0, 8'h00, 0, 0, 0);
    drv(1, 0, 8'h00, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("por");
    arst = 1'b0;

    // streaming through the skid stage
    drv(0, 1, 8'h11, 1, 0, 0); tick();
    drv(0, 1, 8'h22, 1, 0, 0); tick();
    drv(0, 1, 8'h33, 1, 0, 0); tick();
    drv(0, 0, 8'h00, 1, 0, 0); tick(); tick();

    // back-pressure fills both entries, then drains in order
    drv(0, 1, 8'hA1, 0, 0, 0); tick();
    drv(0, 1, 8'hA2, 0, 0, 0); tick();
    drv(0, 1, 8'hEE, 0, 0, 0); tick();
    chk("full.in_ready", 32'(in_ready[0]), 32'd0);
    drv(0, 0, 8'h00, 1, 0, 0); tick(); tick(); tick();

    // flush while full, incoming 0xB3 dropped
    drv(0, 1, 8'hC1, 0, 0, 0); tick();
    drv(0, 1, 8'hC2, 0, 0, 0); tick();
    drv(0, 1, 8'hB3, 0, 1, 0); tick();
    drv(0, 0, 8'h00, 0, 0, 0);
    chk("flush.out_valid", 32'(out_valid[0]), 32'd0);
    chk("flush.out_data", 32'(out_data[0]), 32'h00);
    tick(); tick();

    // asynchronous reset while full
    drv(0, 1, 8'hD1, 0, 0, 0); tick();
    drv(0, 1, 8'hD2, 0, 0, 0); tick();
    drv(0, 1, 8'hD3, 0, 0, 0);
    #2 arst = 1'b1;
    #1 check_reset("arst_async");
    @(posedge clk);
    #1 check_reset("arst_hold");
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    drv(0, 0, 8'h00, 0, 0, 0);
    tick();

    // single-entry stage: in_ready follows out_ready combinationally
    drv(1, 1, 8'hE1, 0, 0, 0); tick();
    drv(1, 1, 8'hE2, 0, 0, 0); tick();
    drv(1, 1, 8'hE2, 1, 0, 0); tick();
    drv(1, 0, 8'h00, 1, 0, 0); tick();

    // stall counter saturation and clear (3-bit counter)
    drv(1, 1, 8'hF1, 1, 0, 0); tick();
    drv(1, 0, 8'h00, 0, 0, 0);
    repeat (10) tick();
    chk("sat.stall_cnt", get_cnt(1), 32'd7);
    drv(1, 0, 8'h00, 0, 0, 1); tick();
    drv(1, 0, 8'h00, 0, 0, 0);
    chk("clr.stall_cnt", get_cnt(1), 32'd0);
    tick();
    drv(1, 0, 8'h00, 1, 0, 0); tick();

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        drv(k,
            $urandom_range(0, 3) != 0,
            8'($urandom),
            ((i / 64) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
